// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, register/data types, the issue bundle carried by the
// operand-fetch pipeline register, and the output-register state encoding.
package rf_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int OP_W   = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    reg_addr_t       rd;
    logic            wen;
    data_t           a;
    data_t           b;
  } issue_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/operand_scoreboard.sv
// operand_scoreboard: one busy bit per register, marking a pending write.
//   set_en/rd    : accepted instruction that will write rd (sets busy)
//   wb_valid/addr: writeback releasing a register (clears busy)
//   rs1/rs2/rd/wen: instruction presented for issue
//   hazard       : RAW on either source, or WAW on rd when wen=1
// Build option WB_BYPASS_EN: a register being written back this cycle is
// treated as free for hazard purposes (its value is forwarded by the top).
module operand_scoreboard
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  reg_addr_t rd,
  input  logic      wen,
  input  logic      set_en,
  input  logic      wb_valid,
  input  reg_addr_t wb_addr,
  output logic      hazard
);
  logic [NREGS-1:0] busy_q, busy_d, busy_eff;

  always_comb begin
    busy_eff = busy_q;
`ifdef WB_BYPASS_EN
    if (wb_valid) busy_eff[wb_addr] = 1'b0;
`endif
    hazard = busy_eff[rs1] | busy_eff[rs2] | (wen & busy_eff[rd]);
  end

  // Clear first, then set: a same-cycle set on the written-back register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (set_en)   busy_d[rd]      = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads both source operands from the register file,
// holds issue on scoreboard hazards, and latches the instruction plus
// operands into a single-entry pipeline register for the execute stage.
//   in_*    : decoded instruction handshake (valid/ready)
//   rf_*    : register-file read port (combinational data), rf_mode fixed 0
//   wb_*    : writeback stream, releases scoreboard entries
//   out_*   : execute handshake and latched fields
//   stall_count: saturating count of cycles with in_valid & hazard
// Build option WB_BYPASS_EN: forward wb_value to a matching source in the
// writeback cycle so a dependent instruction issues without waiting.
module operand_fetch_stage
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  output logic              rf_mode,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_value1,
  input  logic [DATA_W-1:0] rf_read_value2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wen,
  output logic [15:0]       stall_count
);
  out_state_e  state_q, state_d;
  issue_t      iss_q, iss_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        hazard, accept;
  data_t       op_a, op_b;

  assign rf_mode       = 1'b0;
  assign rf_read_addr1 = in_rs1;
  assign rf_read_addr2 = in_rs2;

  operand_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .rd       (in_rd),
    .wen      (in_wen),
    .set_en   (accept & in_wen),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .hazard   (hazard)
  );

  assign out_valid = (state_q == OUT_FULL);
  assign in_ready  = !hazard & (!out_valid | out_ready);
  assign accept    = in_valid & in_ready;

  always_comb begin
    op_a = rf_read_value1;
    op_b = rf_read_value2;
`ifdef WB_BYPASS_EN
    if (wb_valid && wb_addr == in_rs1) op_a = wb_value;
    if (wb_valid && wb_addr == in_rs2) op_b = wb_value;
`endif
  end

`ifndef WB_BYPASS_EN
  // Without forwarding the data arrives through the register file instead.
  logic unused_wb_value;
  assign unused_wb_value = ^wb_value;
`endif

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    if (accept) begin
      state_d = OUT_FULL;
      iss_d   = '{op: in_op, rd: in_rd, wen: in_wen, a: op_a, b: op_b};
    end else if (out_ready) begin
      state_d = OUT_EMPTY;  // fields keep their last value
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (in_valid && hazard && stall_count_q != 16'hFFFF)
      stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= OUT_EMPTY;
      iss_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      iss_q         <= iss_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_op      = iss_q.op;
  assign out_a       = iss_q.a;
  assign out_b       = iss_q.b;
  assign out_rd      = iss_q.rd;
  assign out_wen     = iss_q.wen;
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage with a behavioural 32x16 register file.
// Register i holds {i,i} except r3=0x1111 and r4=0x2222.
module tb_operand_fetch_stage;
  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_wen;
  logic        rf_mode;
  logic [4:0]  rf_read_addr1, rf_read_addr2;
  logic [15:0] rf_read_value1, rf_read_value2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [15:0] wb_value;
  logic        out_valid, out_ready;
  logic [3:0]  out_op;
  logic [15:0] out_a, out_b;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [15:0] stall_count;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] rf [32];

`ifdef WB_BYPASS_EN
  localparam logic [15:0] STALLS_AFTER_DEP = 16'd1;
`else
  localparam logic [15:0] STALLS_AFTER_DEP = 16'd2;
`endif

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
    .rf_mode(rf_mode), .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_value1(rf_read_value1), .rf_read_value2(rf_read_value2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_value(wb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wen(out_wen),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rf_read_value1 = rf[rf_read_addr1];
    rf_read_value2 = rf[rf_read_addr2];
  end

  always @(posedge clk) if (wb_valid) rf[wb_addr] <= wb_value;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        wen;
    logic [3:0]  op;
    logic [15:0] ea, eb;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [3:0] op);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wen = wen; in_op = op;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {i[7:0], i[7:0]};
    rf[3] = 16'h1111;
    rf[4] = 16'h2222;

    tbl[0] = '{rs1: 5'd1,  rs2: 5'd2,  rd: 5'd10, wen: 1'b0, op: 4'd1,  ea: 16'h0101, eb: 16'h0202};
    tbl[1] = '{rs1: 5'd0,  rs2: 5'd31, rd: 5'd0,  wen: 1'b0, op: 4'd2,  ea: 16'h0000, eb: 16'h1F1F};
    tbl[2] = '{rs1: 5'd31, rs2: 5'd0,  rd: 5'd31, wen: 1'b0, op: 4'd15, ea: 16'h1F1F, eb: 16'h0000};
    tbl[3] = '{rs1: 5'd3,  rs2: 5'd4,  rd: 5'd12, wen: 1'b0, op: 4'd6,  ea: 16'h1111, eb: 16'h2222};
    tbl[4] = '{rs1: 5'd9,  rs2: 5'd9,  rd: 5'd9,  wen: 1'b1, op: 4'd9,  ea: 16'h0909, eb: 16'h0909};

    rst_n = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_value = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd0);
    #3;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_a", out_a, 0);
    chk("reset out_b", out_b, 0);
    chk("reset out_op/rd/wen", {out_op, out_rd, out_wen}, 0);
    chk("reset stall_count", stall_count, 0);
    chk("rf_mode", rf_mode, 0);
    chk("reset in_ready", in_ready, 1);
    tick;
    rst_n = 1'b1;
    tick;

    // Back-to-back independent issues, one per cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wen, tbl[i].op);
      #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, 1);
      chk($sformatf("vec%0d rf addrs", i), {rf_read_addr1, rf_read_addr2}, {tbl[i].rs1, tbl[i].rs2});
      tick;
      chk($sformatf("vec%0d out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d out_a", i), out_a, tbl[i].ea);
      chk($sformatf("vec%0d out_b", i), out_b, tbl[i].eb);
      chk($sformatf("vec%0d op/rd/wen", i), {out_op, out_rd, out_wen}, {tbl[i].op, tbl[i].rd, tbl[i].wen});
    end

    // rs1=rs2=rd=9 was accepted and now holds r9 busy.
    drive(1'b0, 5'd1, 5'd9, 5'd13, 1'b0, 4'd0);
    #1;
    chk("r9 busy after self-dep issue", in_ready, 0);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_value = 16'h0909;
    tick;
    wb_valid = 1'b0;
    #1;
    chk("r9 released", in_ready, 1);
    chk("no stall without in_valid", stall_count, 0);
    chk("drain to empty", out_valid, 0);

    // Producer writes r5.
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 4'hA);
    tick;
    chk("prod out_valid", out_valid, 1);
    chk("prod out_a", out_a, 16'h1111);
    chk("prod out_b", out_b, 16'h2222);
    chk("prod rd/wen", {out_rd, out_wen}, {5'd5, 1'b1});

    // Consumer of r5 stalls until the writeback.
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b0, 4'hB);
    #1;
    chk("raw in_ready", in_ready, 0);
    tick;
    chk("raw stall_count", stall_count, 1);
    chk("prod drained", out_valid, 0);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_value = 16'hBEEF;
    #1;
`ifdef WB_BYPASS_EN
    chk("wb cycle in_ready", in_ready, 1);
    tick;
    wb_valid = 1'b0;
`else
    chk("wb cycle in_ready", in_ready, 0);
    tick;
    wb_valid = 1'b0;
    #1;
    chk("post-wb in_ready", in_ready, 1);
    tick;
`endif
    chk("dep out_valid", out_valid, 1);
    chk("dep out_a", out_a, 16'hBEEF);
    chk("dep out_b", out_b, 16'h0101);
    chk("dep stall_count", stall_count, STALLS_AFTER_DEP);
    in_valid = 1'b0;
    tick;

    // Backpressure: hold for 3 cycles, then drain and accept together.
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd10, 1'b0, 4'd3);
    tick;
    drive(1'b1, 5'd11, 5'd12, 5'd14, 1'b0, 4'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d in_ready", i), in_ready, 0);
      chk($sformatf("hold%0d out", i), {out_valid, out_op, out_a, out_b}, {1'b1, 4'd3, 16'h0101, 16'h0202});
      tick;
    end
    chk("hold stall_count", stall_count, STALLS_AFTER_DEP);
    out_ready = 1'b1;
    #1;
    chk("release in_ready", in_ready, 1);
    tick;
    chk("drain+accept out", {out_valid, out_op, out_a, out_b}, {1'b1, 4'd4, 16'h0B0B, 16'h0C0C});
    in_valid = 1'b0;
    tick;
    chk("empty after drain", out_valid, 0);

    // Same-cycle set and clear on r7: set wins.
    wb_valid = 1'b1; wb_addr = 5'd7; wb_value = 16'h7777;
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 4'd5);
    #1;
    chk("set/clear in_ready", in_ready, 1);
    tick;
    wb_valid = 1'b0;
    drive(1'b0, 5'd7, 5'd1, 5'd0, 1'b0, 4'd0);
    #1;
    chk("r7 still busy", in_ready, 0);
    drive(1'b0, 5'd1, 5'd2, 5'd7, 1'b1, 4'd0);
    #1;
    chk("waw blocks", in_ready, 0);
    in_wen = 1'b0;
    #1;
    chk("no waw without wen", in_ready, 1);
    wb_valid = 1'b1; wb_addr = 5'd7;
    tick;
    wb_valid = 1'b0;
    drive(1'b0, 5'd7, 5'd1, 5'd0, 1'b0, 4'd0);
    #1;
    chk("r7 released", in_ready, 1);

    // Long hazard: stall counter saturates.
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd20, 1'b1, 4'd6);
    tick;
    drive(1'b1, 5'd20, 5'd2, 5'd21, 1'b0, 4'd7);
    repeat (70000) tick;
    chk("stall_count saturated", stall_count, 16'hFFFF);
    chk("held through stall", {out_valid, out_op, out_b}, {1'b1, 4'd6, 16'h0202});

    // Asynchronous reset mid-stall.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst fields", {out_op, out_a, out_b, out_rd, out_wen}, 0);
    chk("async rst stall_count", stall_count, 0);
    chk("async rst busy cleared", in_ready, 1);
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
